// File: rtl/move_frame_tx.sv
// move_frame_tx: queues completed moves from the board controller and
// streams each one to the UART transmitter as a 3-byte frame
// {header/high, low, xor checksum} over a valid/ready byte handshake.
module move_frame_tx #(
  parameter int         DEPTH = 4,
  parameter logic [1:0] HDR   = 2'b01
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     moved,
  input  logic [11:0]              output_packet,
  input  logic                     player,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [12:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;

  logic [15:0]     r_frame;
  logic [7:0]      r_csum;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_accept;
  logic [12:0]     w_head;
  logic [7:0]      w_head_b0;
  logic [7:0]      w_head_b1;
  logic [7:0]      w_tx_data_d;
  logic            w_tx_valid_d;

  // FIFO status and the frame bytes of the entry at the head.
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_accept  = r_tx_valid && tx_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_b0 = {HDR, w_head[12], 1'b0, w_head[11:8]};
  assign w_head_b1 = w_head[7:0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO
  // is still accepted when the FSM is popping.
  assign w_push    = moved && (!w_full || w_pop);

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign fifo_count = r_count;
  assign busy       = (r_state != IDLE);
  assign overflow   = r_overflow;

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_tx_valid_d = r_tx_valid;
    w_tx_data_d  = r_tx_data;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = B0;
          w_tx_valid_d = 1'b1;
          w_tx_data_d  = w_head_b0;
        end
      end
      B0: begin
        if (w_accept) begin
          w_next_state = B1;
          w_tx_data_d  = r_frame[7:0];
        end
      end
      B1: begin
        if (w_accept) begin
          w_next_state = B2;
          w_tx_data_d  = r_csum;
        end
      end
      B2: begin
        if (w_accept) begin
          w_next_state = IDLE;
          w_tx_valid_d = 1'b0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_tx_valid_d = 1'b0;
      end
    endcase
  end

  // State register, registered byte interface and frame capture on pop.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_frame    <= '0;
      r_csum     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_tx_valid <= w_tx_valid_d;
      r_tx_data  <= w_tx_data_d;
      if (w_pop) begin
        r_frame <= {w_head_b0, w_head_b1};
        r_csum  <= w_head_b0 ^ w_head_b1;
      end
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (moved && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and count alone define
    // which entries are valid.
    if (w_push) r_mem[r_wr_ptr] <= {player, output_packet};
  end

endmodule

// File: tb/tb_move_frame_tx.sv
// tb_move_frame_tx: directed bench for move_frame_tx with hand-computed
// frame bytes; accepted bytes are logged with their cycle number.
module tb_move_frame_tx;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          moved;
  logic [11:0]   output_packet;
  logic          player;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          overflow;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [7:0] acc_q[$];
  int         acc_cyc[$];

  // Hand-computed frames for the burst moves
  // (0,123) (1,FC0) (0,03F) (1,801).
  logic [7:0] burst_exp [12] = '{8'h41, 8'h23, 8'h62,
                                 8'h6F, 8'hC0, 8'hAF,
                                 8'h40, 8'h3F, 8'h7F,
                                 8'h68, 8'h01, 8'h69};

  move_frame_tx #(.DEPTH(DEPTH), .HDR(2'b01)) dut (
    .clk           (clk),
    .reset         (reset),
    .moved         (moved),
    .output_packet (output_packet),
    .player        (player),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Log every byte accepted at a rising edge together with its cycle.
  always @(posedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      acc_q.push_back(tx_data);
      acc_cyc.push_back(cyc);
    end
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 8'hEE;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    moved         = 1'b0;
    player        = 1'b0;
    output_packet = '0;
    tx_ready      = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    acc_q.delete();
    acc_cyc.delete();
  endtask

  task automatic push_move(input logic p, input logic [11:0] pkt);
    player        = p;
    output_packet = pkt;
    moved         = 1'b1;
    tick(1);
    moved = 1'b0;
  endtask

  // Hold tx_ready high until n bytes total have been accepted, then drop it.
  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    tx_ready = 1'b1;
    while (acc_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tx_ready = 1'b0;
    check(tag, acc_q.size(), n);
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_count", fifo_count, 0);

    // ---------------- single move ----------------
    tx_ready = 1'b1;
    push_move(1'b1, 12'hA5C);
    check("single_count_after_push", fifo_count, 1);
    check("single_busy_before_pop", busy, 1'b0);
    wait_bytes("single_nbytes", 3, 20);
    check("single_b0", byte_at(0), 8'h6A);
    check("single_b1", byte_at(1), 8'h5C);
    check("single_b2", byte_at(2), 8'h36);
    check("single_gap01", cyc_at(1) - cyc_at(0), 1);
    check("single_gap12", cyc_at(2) - cyc_at(1), 1);
    check("single_busy_end", busy, 1'b0);
    check("single_valid_end", tx_valid, 1'b0);
    check("single_count_end", fifo_count, 0);

    // ---------------- backpressure ----------------
    do_reset();
    push_move(1'b1, 12'hA5C);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {tx_valid, tx_data}, {1'b1, 8'h6A});
      tick(1);
    end
    check("bp_no_accept", acc_q.size(), 0);
    tx_ready = 1'b1;
    tick(1);
    check("bp_first_accept_n", acc_q.size(), 1);
    check("bp_first_accept_b0", byte_at(0), 8'h6A);
    wait_bytes("bp_nbytes", 3, 20);
    check("bp_b1", byte_at(1), 8'h5C);
    check("bp_b2", byte_at(2), 8'h36);

    // ---------------- burst ----------------
    do_reset();
    push_move(1'b0, 12'h123);
    push_move(1'b1, 12'hFC0);
    push_move(1'b0, 12'h03F);
    push_move(1'b1, 12'h801);
    check("burst_count", fifo_count, 3);
    check("burst_busy", busy, 1'b1);
    wait_bytes("burst_nbytes", 12, 100);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("burst_byte%0d", i), byte_at(i), burst_exp[i]);
      if (i > 0)
        check($sformatf("burst_gap%0d", i), cyc_at(i) - cyc_at(i-1), (i % 3 == 0) ? 2 : 1);
    end
    check("burst_count_end", fifo_count, 0);
    check("burst_busy_end", busy, 1'b0);

    // ---------------- overflow ----------------
    do_reset();
    for (int i = 0; i < 6; i++) push_move(i[0], 12'h100 + 12'(i));
    check("ovf_count_full", fifo_count, DEPTH);
    check("ovf_flag", overflow, 1'b1);
    wait_bytes("ovf_nbytes", 15, 200);
    tx_ready = 1'b1;
    tick(10);
    tx_ready = 1'b0;
    check("ovf_no_sixth_frame", acc_q.size(), 15);
    for (int f = 0; f < 5; f++)
      check($sformatf("ovf_frame%0d_b1", f), byte_at(3*f + 1), 8'(f));
    check("ovf_sticky", overflow, 1'b1);

    // ---------------- push/pop coincidence ----------------
    do_reset();
    for (int i = 0; i < 5; i++) push_move(1'b0, 12'h200 + 12'(i));
    check("pp_count_full", fifo_count, DEPTH);
    check("pp_no_ovf_yet", overflow, 1'b0);
    wait_bytes("pp_first_frame", 3, 20);
    check("pp_idle", busy, 1'b0);
    push_move(1'b1, 12'h2AA);
    check("pp_count_stays", fifo_count, DEPTH);
    check("pp_no_ovf", overflow, 1'b0);
    check("pp_next_b0", {tx_valid, tx_data}, {1'b1, 8'h42});

    // ---------------- reset mid-frame ----------------
    do_reset();
    push_move(1'b0, 12'h123);
    push_move(1'b1, 12'h456);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    tick(1);
    check("mid_in_b1", {tx_valid, tx_data}, {1'b1, 8'h23});
    check("mid_queued", fifo_count, 1);
    reset = 1'b1;
    #1;
    check("mid_async_valid", tx_valid, 1'b0);
    check("mid_async_count", fifo_count, 0);
    check("mid_async_busy", busy, 1'b0);
    tick(1);
    reset = 1'b0;
    acc_q.delete();
    acc_cyc.delete();
    tx_ready = 1'b1;
    tick(10);
    tx_ready = 1'b0;
    check("mid_no_bytes", acc_q.size(), 0);
    check("mid_count_after", fifo_count, 0);
    check("mid_busy_after", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
